mem_port_arbiter: RTL and testbench

Sequencing controller sharing the single memory port between the IF stage (instruction fetch) and the MEM stage (loads/stores carried by the EX/MEM register's `mem_request_write`/`mem_request_type`). It arbitrates, issues one transaction at a time over a valid/ready port, returns read data to the winner, and produces the per-stage stall signals that drive the pipeline-register `en` inputs. Data accesses have priority, with a starvation guard for fetch and a flush path that kills a pending fetch on branch mispredict.

---
 rtl/mem_port_arbiter.sv | 183 ++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Memory port arbiter: shares one valid/ready memory port between the
// instruction-fetch stage and the data (load/store) stage.
//
//   state | meaning
//   IDLE  | no transaction outstanding, arbitrate eligible requesters
//   ISSUE | port_valid high, waiting for port_ready
//   WAIT  | accepted, waiting for the single port_rvalid response
//
// Data accesses win by default; once STARVE_LIMIT data grants have gone by
// with fetch waiting, fetch wins the next contested slot. A flush kills a
// fetch that is still in ISSUE, or marks one in WAIT so its response is
// swallowed without an if_done.
module mem_port_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_done,
    output logic        if_stall,
    input  logic        flush,
    input  logic        dm_req,
    input  logic        dm_we,
    input  logic [2:0]  dm_type,
    input  logic [31:0] dm_addr,
    input  logic [31:0] dm_wdata,
    output logic [31:0] dm_rdata,
    output logic        dm_done,
    output logic        dm_stall,
    output logic        port_valid,
    input  logic        port_ready,
    output logic        port_we,
    output logic [2:0]  port_type,
    output logic [31:0] port_addr,
    output logic [31:0] port_wdata,
    input  logic        port_rvalid,
    input  logic [31:0] port_rdata
);

    localparam logic [3:0] LIMIT      = 4'(STARVE_LIMIT);
    localparam logic [2:0] FETCH_TYPE = 3'b010;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic       owner_if;     // 1: fetch owns the port, 0: data owns it
    logic       discard;
    logic [3:0] starve_cnt;

    logic       if_elig;
    logic       dm_elig;
    logic       grant_if;
    logic       grant_dm;
    logic       resp;
    logic       set_discard;

    // Stalls are the only combinational paths from inputs to outputs.
    assign if_stall   = if_req & ~if_done;
    assign dm_stall   = dm_req & ~dm_done;
    assign port_valid = (state == S_ISSUE);

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Arbitration, next-state and per-cycle control strobes.
    always_comb begin
        state_nxt   = state;
        grant_if    = 1'b0;
        grant_dm    = 1'b0;
        resp        = 1'b0;
        set_discard = 1'b0;
        // A requester is never regranted in its own done cycle.
        if_elig     = if_req & ~if_done & ~flush;
        dm_elig     = dm_req & ~dm_done;

        case (state)
            S_IDLE: begin
                if (if_elig && (!dm_elig || starve_cnt == LIMIT)) begin
                    grant_if  = 1'b1;
                    state_nxt = S_ISSUE;
                end else if (dm_elig) begin
                    grant_dm  = 1'b1;
                    state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (owner_if && flush) begin
                    // Already accepted this cycle: the response must still be
                    // consumed, so keep the slot and swallow it in WAIT.
                    if (port_ready) begin
                        set_discard = 1'b1;
                        state_nxt   = S_WAIT;
                    end else begin
                        state_nxt   = S_IDLE;
                    end
                end else if (port_ready) begin
                    state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (port_rvalid) begin
                    resp      = 1'b1;
                    state_nxt = S_IDLE;
                end else if (owner_if && flush) begin
                    set_discard = 1'b1;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Port fields, owner, starvation counter, response capture and done pulses.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            port_we    <= 1'b0;
            port_type  <= 3'b000;
            port_addr  <= 32'h0;
            port_wdata <= 32'h0;
            owner_if   <= 1'b0;
            discard    <= 1'b0;
            starve_cnt <= 4'h0;
            if_rdata   <= 32'h0;
            dm_rdata   <= 32'h0;
            if_done    <= 1'b0;
            dm_done    <= 1'b0;
        end else begin
            if_done <= 1'b0;
            dm_done <= 1'b0;

            if (grant_if) begin
                port_we    <= 1'b0;
                port_type  <= FETCH_TYPE;
                port_addr  <= if_addr;
                port_wdata <= 32'h0;
                owner_if   <= 1'b1;
                starve_cnt <= 4'h0;
            end else if (grant_dm) begin
                port_we    <= dm_we;
                port_type  <= dm_type;
                port_addr  <= dm_addr;
                port_wdata <= dm_wdata;
                owner_if   <= 1'b0;
                if (if_req && starve_cnt != LIMIT) begin
                    starve_cnt <= starve_cnt + 4'h1;
                end
            end

            if (set_discard) begin
                discard <= 1'b1;
            end

            if (resp) begin
                if (owner_if) begin
                    // A flush arriving with the response also kills it.
                    if (!(discard || flush)) begin
                        if_rdata <= port_rdata;
                        if_done  <= 1'b1;
                    end
                    discard <= 1'b0;
                end else begin
                    dm_rdata <= port_rdata;
                    dm_done  <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a vector table of single data
// transactions plus hand-written contention, starvation, flush and reset
// sequences. A small memory model answers the port with programmable
// ready/response delays.
module tb_mem_port_arbiter;

    logic        clk;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_done;
    logic        if_stall;
    logic        flush;
    logic        dm_req;
    logic        dm_we;
    logic [2:0]  dm_type;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [31:0] dm_rdata;
    logic        dm_done;
    logic        dm_stall;
    logic        port_valid;
    logic        port_ready;
    logic        port_we;
    logic [2:0]  port_type;
    logic [31:0] port_addr;
    logic [31:0] port_wdata;
    logic        port_rvalid;
    logic [31:0] port_rdata;

    mem_port_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .if_req     (if_req),
        .if_addr    (if_addr),
        .if_rdata   (if_rdata),
        .if_done    (if_done),
        .if_stall   (if_stall),
        .flush      (flush),
        .dm_req     (dm_req),
        .dm_we      (dm_we),
        .dm_type    (dm_type),
        .dm_addr    (dm_addr),
        .dm_wdata   (dm_wdata),
        .dm_rdata   (dm_rdata),
        .dm_done    (dm_done),
        .dm_stall   (dm_stall),
        .port_valid (port_valid),
        .port_ready (port_ready),
        .port_we    (port_we),
        .port_type  (port_type),
        .port_addr  (port_addr),
        .port_wdata (port_wdata),
        .port_rvalid(port_rvalid),
        .port_rdata (port_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // memory model state
    int          mem_rdy_wait;
    int          mem_rv_wait;
    logic [31:0] mem_rdata;
    logic        rd_from_addr;
    logic        pend;
    logic        stray;
    int          rdy_cnt;
    int          rv_cnt;

    typedef struct packed {
        logic        we;
        logic [2:0]  typ;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic [7:0]  rdy_wait;
        logic [7:0]  rv_wait;
        logic [7:0]  exp_lat;
    } vec_t;

    vec_t vecs [4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Advance one clock; update the memory model from what happened at the edge.
    task automatic step();
        logic acc;
        logic fired;
        acc   = port_valid & port_ready;
        fired = port_rvalid;
        @(posedge clk);
        #1;
        if (acc) begin
            pend   = 1'b1;
            rv_cnt = 0;
        end
        if (fired) pend = 1'b0;
        if (port_valid) begin
            port_ready = (rdy_cnt >= mem_rdy_wait);
            rdy_cnt++;
        end else begin
            port_ready = 1'b0;
            rdy_cnt    = 0;
        end
        if (pend) begin
            port_rvalid = (rv_cnt >= mem_rv_wait);
            rv_cnt++;
        end else begin
            port_rvalid = stray;
        end
        port_rdata = rd_from_addr ? ~port_addr : mem_rdata;
    endtask

    task automatic wait_done(input logic is_if, input string name);
        int n = 0;
        while (((is_if ? if_done : dm_done) !== 1'b1) && n < 30) begin
            step();
            n++;
        end
        chk(name, 32'((is_if ? if_done : dm_done) === 1'b1), 32'h1);
        if (is_if) if_req = 1'b0;
        else       dm_req = 1'b0;
    endtask

    task automatic run_dm(input vec_t v, input string nm);
        int lat;
        int field_err;
        int stall_err;
        mem_rdy_wait = int'(v.rdy_wait);
        mem_rv_wait  = int'(v.rv_wait);
        mem_rdata    = v.rdata;
        rd_from_addr = 1'b0;
        dm_we    = v.we;
        dm_type  = v.typ;
        dm_addr  = v.addr;
        dm_wdata = v.wdata;
        dm_req   = 1'b1;
        #1;
        lat = 0;
        field_err = 0;
        stall_err = 0;
        if (dm_stall !== 1'b1) stall_err++;
        while (dm_done !== 1'b1 && lat < 40) begin
            step();
            lat++;
            if (lat == 1) chk({nm, "_valid_c1"}, 32'(port_valid), 32'h1);
            if (port_valid && (port_we !== v.we || port_type !== v.typ ||
                               port_addr !== v.addr || port_wdata !== v.wdata))
                field_err++;
            if (dm_done !== 1'b1 && dm_stall !== 1'b1) stall_err++;
        end
        chk({nm, "_latency"}, 32'(lat), 32'(v.exp_lat));
        chk({nm, "_rdata"}, dm_rdata, v.rdata);
        chk({nm, "_fields"}, 32'(field_err), 32'h0);
        chk({nm, "_stall"}, 32'(stall_err), 32'h0);
        chk({nm, "_stall_done"}, 32'(dm_stall), 32'h0);
        dm_req = 1'b0;
        step();
        chk({nm, "_done_pulse"}, 32'(dm_done), 32'h0);
        chk({nm, "_rdata_hold"}, dm_rdata, v.rdata);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int bad;
        int ndone;
        int n;

        //           we    type    addr          wdata         rdata         rdy   rv    lat
        vecs[0] = '{1'b0, 3'b010, 32'h0000_0100, 32'h0,        32'hDEADBEEF, 8'd0, 8'd0, 8'd3};
        vecs[1] = '{1'b1, 3'b010, 32'h0000_0104, 32'h12345678, 32'h0,        8'd3, 8'd0, 8'd6};
        vecs[2] = '{1'b0, 3'b100, 32'h0000_0203, 32'h0,        32'h0000_00A5, 8'd1, 8'd2, 8'd6};
        vecs[3] = '{1'b1, 3'b001, 32'hFFFF_FFFC, 32'hCAFEF00D, 32'h1111_1111, 8'd0, 8'd1, 8'd4};

        rst = 1'b0;
        if_req = 1'b0; if_addr = 32'h0; flush = 1'b0;
        dm_req = 1'b0; dm_we = 1'b0; dm_type = 3'b000; dm_addr = 32'h0; dm_wdata = 32'h0;
        port_ready = 1'b0; port_rvalid = 1'b0; port_rdata = 32'h0;
        mem_rdy_wait = 0; mem_rv_wait = 0; mem_rdata = 32'h0; rd_from_addr = 1'b0;
        pend = 1'b0; stray = 1'b0; rdy_cnt = 0; rv_cnt = 0;

        step();
        step();
        chk("rst_port_valid", 32'(port_valid), 32'h0);
        chk("rst_port_addr", port_addr, 32'h0);
        chk("rst_port_we", 32'(port_we), 32'h0);
        chk("rst_port_type", 32'(port_type), 32'h0);
        chk("rst_port_wdata", port_wdata, 32'h0);
        chk("rst_if_rdata", if_rdata, 32'h0);
        chk("rst_dm_rdata", dm_rdata, 32'h0);
        chk("rst_dones", {30'h0, if_done, dm_done}, 32'h0);
        rst = 1'b1;
        step();

        // table-driven single data transactions
        for (int i = 0; i < 4; i++) begin
            run_dm(vecs[i], $sformatf("vec%0d", i));
            step();
        end

        // contention: DM first, IF granted in DM's done cycle
        rd_from_addr = 1'b1; mem_rdy_wait = 0; mem_rv_wait = 0;
        if_req = 1'b1; if_addr = 32'h400;
        dm_req = 1'b1; dm_we = 1'b0; dm_type = 3'b000; dm_addr = 32'h300; dm_wdata = 32'h0;
        #1;
        bad = 0;
        for (int c = 1; c <= 6; c++) begin
            step();
            if (c == 1) chk("cont_dm_first", port_addr, 32'h300);
            if (c == 3) begin
                chk("cont_dm_done_c3", 32'(dm_done), 32'h1);
                dm_req = 1'b0;
            end
            if (c == 4) begin
                chk("cont_if_valid_c4", 32'(port_valid), 32'h1);
                chk("cont_if_addr_c4", port_addr, 32'h400);
                chk("cont_if_type_c4", 32'(port_type), 32'h2);
            end
            if (c < 6 && if_stall !== 1'b1) bad++;
            if (c == 6) begin
                chk("cont_if_done_c6", 32'(if_done), 32'h1);
                chk("cont_if_rdata", if_rdata, ~32'h400);
                chk("cont_if_stall_done", 32'(if_stall), 32'h0);
            end
        end
        chk("cont_if_stall_held", 32'(bad), 32'h0);
        if_req = 1'b0;
        step();
        step();

        // starvation: flush keeps fetch out of the DM done cycles
        if_req = 1'b1; if_addr = 32'h500; flush = 1'b1;
        dm_req = 1'b1; dm_addr = 32'h600; dm_type = 3'b010;
        ndone = 0; bad = 0; n = 0;
        while (ndone < 4 && n < 60) begin
            step();
            n++;
            if (port_valid && port_addr !== 32'h600) bad++;
            if (dm_done) ndone++;
            if (if_done) bad++;
        end
        chk("starve_dm_grants", 32'(ndone), 32'h4);
        chk("starve_dm_only", 32'(bad), 32'h0);
        step();
        chk("starve_idle_gap", 32'(port_valid), 32'h0);
        flush = 1'b0;
        step();
        chk("starve_if_wins_valid", 32'(port_valid), 32'h1);
        chk("starve_if_wins_addr", port_addr, 32'h500);
        wait_done(1'b1, "starve_if_done");
        dm_req = 1'b0;
        chk("starve_if_rdata", if_rdata, ~32'h500);
        step();
        step();
        // counter cleared by the IF grant: DM wins the next contested slot
        if_req = 1'b1; if_addr = 32'h510;
        dm_req = 1'b1; dm_addr = 32'h610;
        step();
        chk("starve_cleared_dm_first", port_addr, 32'h610);
        wait_done(1'b0, "starve_cleared_dm_done");
        wait_done(1'b1, "starve_cleared_if_done");
        step();

        // flush while fetch is in WAIT
        rd_from_addr = 1'b1; mem_rdy_wait = 0; mem_rv_wait = 2;
        if_req = 1'b1; if_addr = 32'h700;
        bad = 0;
        step();                                     // c1
        chk("flw_issue_addr", port_addr, 32'h700);
        step();                                     // c2 WAIT
        flush = 1'b1;
        step();                                     // c3
        flush = 1'b0; if_addr = 32'h200;
        if (if_done) bad++;
        step();                                     // c4 response arrives
        mem_rv_wait = 0;
        if (if_done) bad++;
        step();                                     // c5 IDLE
        if (if_done) bad++;
        chk("flw_idle_c5", 32'(port_valid), 32'h0);
        chk("flw_rdata_kept", if_rdata, ~32'h510);
        step();                                     // c6
        if (if_done) bad++;
        chk("flw_refetch_valid", 32'(port_valid), 32'h1);
        chk("flw_refetch_addr", port_addr, 32'h200);
        step();                                     // c7
        if (if_done) bad++;
        step();                                     // c8
        chk("flw_no_killed_done", 32'(bad), 32'h0);
        chk("flw_refetch_done", 32'(if_done), 32'h1);
        chk("flw_refetch_rdata", if_rdata, ~32'h200);
        if_req = 1'b0;
        step();

        // flush while fetch is in ISSUE
        mem_rdy_wait = 5;
        if_req = 1'b1; if_addr = 32'h800;
        step();
        chk("fli_valid_c1", 32'(port_valid), 32'h1);
        flush = 1'b1;
        step();
        chk("fli_drop", 32'(port_valid), 32'h0);
        flush = 1'b0; if_req = 1'b0;
        bad = 0;
        for (int c = 0; c < 6; c++) begin
            step();
            if (if_done || port_valid) bad++;
        end
        chk("fli_no_done", 32'(bad), 32'h0);
        mem_rdy_wait = 0;

        // reset while a load is in WAIT, then a stray response
        rd_from_addr = 1'b0; mem_rv_wait = 10; mem_rdata = 32'h55AA55AA;
        dm_req = 1'b1; dm_we = 1'b0; dm_type = 3'b000; dm_addr = 32'h900;
        step();
        step();
        chk("rw_in_wait_addr", port_addr, 32'h900);
        rst = 1'b0;
        #1;
        chk("rw_port_addr", port_addr, 32'h0);
        chk("rw_port_valid", 32'(port_valid), 32'h0);
        chk("rw_dm_rdata", dm_rdata, 32'h0);
        chk("rw_if_rdata", if_rdata, 32'h0);
        dm_req = 1'b0; pend = 1'b0; port_rvalid = 1'b0;
        step();
        rst = 1'b1;
        step();
        bad = 0;
        stray = 1'b1;
        step();
        stray = 1'b0;
        for (int c = 0; c < 3; c++) begin
            if (dm_done || if_done || port_valid) bad++;
            step();
        end
        chk("rw_stray_ignored", 32'(bad), 32'h0);
        chk("rw_stray_rdata", dm_rdata, 32'h0);
        run_dm(vecs[0], "rw_after");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
